// File: rtl/tone_divider.sv
// tone_divider: runtime-programmable 50%-duty tone generator, one per voice.
// O_CLK = I_CLK / (2 * half-period). A new half-period loaded while running is
// held in a shadow register and only takes effect at a toggle boundary, so no
// phase is ever truncated or stretched. The gate (en) always lets a high phase
// finish before the tone stops; a half-period of 0 mutes the voice.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no tone, O_CLK held low, counter cleared, loads go to active
//   ST_RUN   | tone running, counter advances, toggles at cnt == active-1
//   ST_DRAIN | gate off or mute seen while high: finish high phase, then idle
module tone_divider #(
    parameter int WIDTH        = 17,
    parameter int HALF_DEFAULT = 50000
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             O_CLK,
    output logic             O_TICK,
    output logic             O_ACTIVE,
    output logic             O_PENDING
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_HALF_DEFAULT = WIDTH'(HALF_DEFAULT);
    localparam logic [WIDTH-1:0] C_ONE          = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO         = '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_active;   // half-period governing the current phase
    logic [WIDTH-1:0] r_pend;     // shadow half-period waiting for a boundary
    logic             r_pflag;    // r_pend holds a value not yet applied
    logic [WIDTH-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic             r_mute;     // draining a high phase because 0 was applied

    logic             w_toggle;
    logic             w_gate;
    logic [WIDTH-1:0] w_next_half;
    logic [WIDTH-1:0] w_bound_half;

    // Toggle event: last cycle of the current phase.
    assign w_toggle = (r_cnt == (r_active - C_ONE));

    // A mute drain behaves like gate-off until the high phase completes.
    assign w_gate = en & ~r_mute;

    // Newest half-period wins: a strobe this cycle beats the shadow value,
    // which beats the stored one. Used both in IDLE and at a boundary.
    assign w_next_half = div_load ? div_in : (r_pflag ? r_pend : r_active);

    // At the falling boundary of a mute drain, the zero that caused the mute
    // was already consumed at the rising boundary; unless something newer has
    // arrived since, the voice must end up with active = 0.
    assign w_bound_half = (r_mute && !div_load && !r_pflag) ? C_ZERO : w_next_half;

    // Sequencer: counter, output phase, half-period handover and gating.
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_active <= C_HALF_DEFAULT;
            r_pend   <= C_HALF_DEFAULT;
            r_pflag  <= 1'b0;
            r_cnt    <= C_ZERO;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
            r_mute   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk  <= 1'b0;
                    r_cnt  <= C_ZERO;
                    r_mute <= 1'b0;
                    // No phase is running, so any new or pending value can be
                    // applied straight away.
                    if (div_load || r_pflag) begin
                        r_active <= w_next_half;
                        r_pflag  <= 1'b0;
                    end
                    // Start decision uses the value that will govern the first
                    // phase, so a pending copy and a start on the same edge
                    // agree on the half-period.
                    if (en && (w_next_half != C_ZERO)) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    if (!w_gate && !r_clk) begin
                        // Gate off during a low phase: stop at once, nothing
                        // to finish. Any load is kept for IDLE to pick up.
                        r_state <= ST_IDLE;
                        r_cnt   <= C_ZERO;
                        if (div_load) begin
                            r_pend  <= div_in;
                            r_pflag <= 1'b1;
                        end
                    end else if (w_toggle) begin
                        r_cnt   <= C_ZERO;
                        r_clk   <= ~r_clk;
                        r_pflag <= 1'b0;
                        if (!r_clk) begin
                            // Rising boundary (gate is necessarily on here).
                            r_tick <= 1'b1;
                            if (w_bound_half == C_ZERO) begin
                                // Mute: keep the old half-period so the high
                                // phase that just started has normal length.
                                r_state <= ST_DRAIN;
                                r_mute  <= 1'b1;
                            end else begin
                                r_active <= w_bound_half;
                                r_state  <= ST_RUN;
                            end
                        end else begin
                            // Falling boundary: tone may continue or stop.
                            r_active <= w_bound_half;
                            r_mute   <= 1'b0;
                            if (w_gate && (w_bound_half != C_ZERO)) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                        // Only reachable with gate off while high: drain.
                        // Gate returning during a drain resumes seamlessly.
                        r_state <= w_gate ? ST_RUN : ST_DRAIN;
                        if (div_load) begin
                            r_pend  <= div_in;
                            r_pflag <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= C_ZERO;
                    r_clk   <= 1'b0;
                    r_mute  <= 1'b0;
                end
            endcase
        end
    end

    assign O_CLK     = r_clk;
    assign O_TICK    = r_tick;
    assign O_ACTIVE  = (r_state != ST_IDLE);
    assign O_PENDING = r_pflag;

endmodule

// File: tb/tb_tone_divider.sv
// Directed bench for tone_divider. Expected phase lengths are queued as each
// step is driven; a monitor pops one per O_CLK transition and compares the
// measured length. The monitor also checks O_TICK against O_CLK's 0->1 edges.
// HALF_DEFAULT is reduced to 40 to keep the run short.
module tb_tone_divider;

    localparam int WIDTH = 17;
    localparam int HALF  = 40;

    logic             I_CLK;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             O_CLK;
    logic             O_TICK;
    logic             O_ACTIVE;
    logic             O_PENDING;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_chg = 0;
    logic prev_clk = 1'b0;
    logic mon_on = 1'b0;
    int exp_q[$];

    tone_divider #(.WIDTH(WIDTH), .HALF_DEFAULT(HALF)) dut (
        .I_CLK    (I_CLK),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .O_CLK    (O_CLK),
        .O_TICK   (O_TICK),
        .O_ACTIVE (O_ACTIVE),
        .O_PENDING(O_PENDING)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Phase-length scoreboard and tick monitor, sampled on the falling edge.
    always @(negedge I_CLK) begin
        int e;
        if (mon_on) begin
            if (O_CLK !== prev_clk) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("phase_len", cyc - last_chg, e);
                end
                last_chg = cyc;
            end
            check("tick", {31'd0, O_TICK}, {31'd0, O_CLK & ~prev_clk});
        end
        prev_clk = O_CLK;
    end

    task automatic nxt();
        @(negedge I_CLK);
        #1;
    endtask

    task automatic wait_level(input logic lvl, input string tag);
        int n = 0;
        while (O_CLK !== lvl && n < 400) begin
            nxt();
            n++;
        end
        check(tag, {31'd0, O_CLK}, {31'd0, lvl});
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 600) begin
            nxt();
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (O_ACTIVE !== 1'b0 && n < 400) begin
            nxt();
            n++;
        end
        check(tag, {31'd0, O_ACTIVE}, 0);
    endtask

    task automatic hold_low(input int n, input string tag);
        int hi = 0;
        repeat (n) begin
            nxt();
            if (O_CLK !== 1'b0 || O_ACTIVE !== 1'b0) hi++;
        end
        check(tag, hi, 0);
    endtask

    task automatic start_mark();
        last_chg = cyc + 1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0;
        repeat (3) nxt();
        check("rst_clk",     {31'd0, O_CLK},     0);
        check("rst_tick",    {31'd0, O_TICK},    0);
        check("rst_active",  {31'd0, O_ACTIVE},  0);
        check("rst_pending", {31'd0, O_PENDING}, 0);
        mon_on = 1'b1;

        // Default half-period: two full periods, then gate off in a low phase.
        rst = 1'b0; en = 1'b1; start_mark();
        exp_q.push_back(HALF); exp_q.push_back(HALF);
        exp_q.push_back(HALF); exp_q.push_back(HALF);
        wait_empty("default_period");
        check("default_low_now", {31'd0, O_CLK}, 0);
        en = 1'b0;
        nxt();
        check("gate_off_low_active", {31'd0, O_ACTIVE}, 0);
        hold_low(12, "gate_off_low_hold");

        // Start at 10, load 4 when cnt == 3: current phase stays 10.
        div_load = 1'b1; div_in = 17'd10; en = 1'b1; start_mark();
        exp_q.push_back(10); exp_q.push_back(4);
        exp_q.push_back(4);  exp_q.push_back(4);
        nxt(); div_load = 1'b0;
        repeat (3) nxt();
        div_load = 1'b1; div_in = 17'd4;
        nxt(); div_load = 1'b0;
        check("load_pending_set", {31'd0, O_PENDING}, 1);
        wait_level(1'b1, "load_first_rise");
        check("load_pending_clear", {31'd0, O_PENDING}, 0);
        wait_empty("load_phases");

        // Restart at 8, drop gate 2 cycles into the high phase.
        en = 1'b0;
        wait_idle("stop_before_drain");
        nxt();
        div_load = 1'b1; div_in = 17'd8; en = 1'b1; start_mark();
        exp_q.push_back(8);
        nxt(); div_load = 1'b0;
        wait_level(1'b1, "drain_rise");
        exp_q.push_back(8);
        nxt(); en = 1'b0;
        nxt();
        check("drain_active", {31'd0, O_ACTIVE}, 1);
        check("drain_high",   {31'd0, O_CLK},    1);
        wait_level(1'b0, "drain_fall");
        check("drain_idle", {31'd0, O_ACTIVE}, 0);
        wait_empty("drain_phases");
        hold_low(12, "drain_hold");

        // Two loads before a boundary (6 then 3): only 3 applies.
        nxt();
        en = 1'b1; start_mark();
        exp_q.push_back(8);
        wait_level(1'b1, "dbl_rise");
        exp_q.push_back(8); exp_q.push_back(3); exp_q.push_back(3);
        div_load = 1'b1; div_in = 17'd6;
        nxt(); div_in = 17'd3;
        nxt(); div_load = 1'b0;
        check("dbl_pending", {31'd0, O_PENDING}, 1);
        wait_empty("dbl_phases");

        // Load coinciding with the toggle cycle: applied at that boundary.
        exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(5);
        nxt(); nxt();
        div_load = 1'b1; div_in = 17'd5;
        nxt(); div_load = 1'b0;
        check("coincide_no_pending", {31'd0, O_PENDING}, 0);
        wait_empty("coincide_phases");

        // Mute loaded during a high phase: stop at the falling boundary.
        wait_level(1'b0, "mute_hi_pre");
        wait_level(1'b1, "mute_hi_rise");
        exp_q.push_back(5);
        div_load = 1'b1; div_in = '0;
        nxt(); div_load = 1'b0;
        check("mute_hi_pending", {31'd0, O_PENDING}, 1);
        wait_level(1'b0, "mute_hi_fall");
        check("mute_hi_idle", {31'd0, O_ACTIVE}, 0);
        wait_empty("mute_hi_phases");
        hold_low(12, "mute_hi_hold_en1");

        // Mute loaded during a low phase: rise, drain full high phase, stop.
        div_load = 1'b1; div_in = 17'd5; start_mark();
        exp_q.push_back(5); exp_q.push_back(5);
        nxt(); div_in = '0;
        nxt(); div_load = 1'b0;
        check("mute_lo_pending", {31'd0, O_PENDING}, 1);
        wait_level(1'b1, "mute_lo_rise");
        check("mute_lo_drain_active", {31'd0, O_ACTIVE},  1);
        check("mute_lo_drain_pend",   {31'd0, O_PENDING}, 0);
        wait_level(1'b0, "mute_lo_fall");
        check("mute_lo_idle", {31'd0, O_ACTIVE}, 0);
        wait_empty("mute_lo_phases");
        hold_low(12, "mute_lo_hold_en1");

        // Half-period 1: toggle every cycle, tick every 2 cycles.
        div_load = 1'b1; div_in = 17'd1; start_mark();
        for (int i = 0; i < 8; i++) exp_q.push_back(1);
        nxt(); div_load = 1'b0;
        wait_empty("fast_phases");

        // Reset while high: everything low on that edge, then default restart.
        wait_level(1'b1, "rst_mid_high");
        rst = 1'b1;
        nxt();
        check("rst_mid_clk",     {31'd0, O_CLK},     0);
        check("rst_mid_tick",    {31'd0, O_TICK},    0);
        check("rst_mid_active",  {31'd0, O_ACTIVE},  0);
        check("rst_mid_pending", {31'd0, O_PENDING}, 0);
        nxt();
        rst = 1'b0; start_mark();
        exp_q.push_back(HALF); exp_q.push_back(HALF);
        wait_empty("rst_restart_phases");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tone_divider.md
Name: tone_divider

Overview:
- Runtime-programmable 50%-duty tone divider. Successor to the fixed 2 kHz divider.
- Divides I_CLK by 2*half-period. The half-period is loadable while running and is applied glitch-free at a toggle boundary.
- Adds a gate (note on/off) that always finishes a high phase cleanly, a mute code, and a rising-edge tick.
- Sits between the key/note decoder and the audio output pin; one instance per voice.

Parameters:
- WIDTH, 17, width of the half-period value and internal counter.
- HALF_DEFAULT, 50000, half-period in I_CLK cycles loaded at reset; must fit in WIDTH bits.

Ports:
- I_CLK  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; clock I_CLK.
- en  in  1  gate: 1 = tone on, 0 = tone off (level, sampled each cycle).
- div_in  in  WIDTH  requested half-period in I_CLK cycles; 0 = mute.
- div_load  in  1  one-cycle strobe capturing div_in.
- O_CLK  out  1  divided tone output, registered.
- O_TICK  out  1  one-cycle pulse on the cycle O_CLK goes 0->1.
- O_ACTIVE  out  1  1 while state is RUN or DRAIN.
- O_PENDING  out  1  1 while a loaded value waits for the next toggle boundary.

Behaviour:
- Registers:
  - active: current half-period.
  - pend: shadow half-period.
  - pflag: pending flag.
  - cnt: WIDTH-bit counter.
  - state: IDLE / RUN / DRAIN.
- Reset (synchronous, rst=1 at an I_CLK edge):
  - O_CLK=0, O_TICK=0, O_ACTIVE=0, O_PENDING=0.
  - cnt=0, active=pend=HALF_DEFAULT, state=IDLE.
  - Reset mid-tone forces O_CLK low on that same edge, with no drain phase.
- IDLE:
  - O_CLK=0, cnt=0.
  - div_load copies div_in directly into active next edge; pflag stays 0.
  - If en=1 and the effective active is nonzero: go to RUN, cnt=0. The effective active is div_in when div_load is high that cycle, otherwise the stored active.
- RUN:
  - cnt increments each edge.
  - At cnt==active-1 (the toggle event): O_CLK inverts and cnt=0 on the next edge.
  - Start latency: en sampled at edge k means state=RUN at k, first O_CLK rise after edge k+active, and period exactly 2*active cycles.
  - active=1 gives a toggle every cycle (I_CLK/2).
- Load while RUN/DRAIN:
  - div_load sets pend=div_in, pflag=1. Repeated loads before a boundary: last one wins.
  - At a toggle event with pflag=1: active=pend, pflag=0. The new value governs the phase that starts at that toggle, so no truncated or stretched phase other than the boundary itself.
  - div_load in the same cycle as a toggle event: div_in goes straight to active and pflag=0 (newest wins).
- Mute:
  - If the value applied at a boundary is 0, treat it as gate-off at that boundary.
  - If O_CLK becomes 0 there, go to IDLE. If it becomes 1, go to DRAIN using the old active for the remaining high phase.
- Gate off (en=0 in RUN):
  - O_CLK=0: go to IDLE next edge, cnt=0, no further edges.
  - O_CLK=1: go to DRAIN and continue counting. At the toggle event O_CLK falls and state goes to IDLE.
  - In DRAIN, en returning to 1 goes back to RUN without any phase disturbance.
- Pending in IDLE:
  - If pflag=1 on entering IDLE, pend is copied to active on the next edge and pflag clears.
- O_TICK=1 exactly on the cycle following the edge where O_CLK went 0->1; otherwise 0.
- O_ACTIVE = (state != IDLE). O_PENDING = pflag.
- Counter never exceeds active-1. No wrap-around beyond 2^WIDTH-1 is reachable.

Test Plan:
- Reset, en=1 held, default 50000 -> first O_CLK rise 50000 cycles after the en edge, period 100000, O_TICK once per period, duty exactly 50000/50000.
- Running with active=10, div_load div_in=4 at cnt=3 -> O_PENDING=1 until the next toggle. The current phase still lasts 10 cycles, all later phases last 4, and O_PENDING clears.
- Running with active=8, en dropped 2 cycles into a high phase -> O_CLK stays high 6 more cycles, falls, then O_ACTIVE=0. Dropped during a low phase -> O_ACTIVE=0 next cycle and O_CLK stays 0.
- Two loads (6 then 3) before a boundary -> only 3 is applied. A load coinciding with the toggle cycle -> that value is applied at that boundary.
- div_in=0 loaded while running -> tone stops at the next boundary after completing any high phase. active=1 -> O_CLK toggles every cycle, O_TICK every 2 cycles.
- rst asserted while O_CLK=1 mid-phase -> all outputs 0 on that edge. After release with en=1, first rise after HALF_DEFAULT cycles.
